// File: rtl/gf_reduce_8.sv
//-----------------------------------------------------------------------------
// gf_reduce_8
//
// Reduces a 15-bit carry-less GF(2) product modulo the degree-8 polynomial
// x^8 + POLY.
//
// The reduction is done serially, one bit position per cycle. Bit positions
// 14 down to 8 are each eliminated in turn, so every operation spends exactly
// 7 cycles in BUSY, whatever the data is.
//
// Handshake
//   - A product is accepted in IDLE when in_valid=1.
//   - The result is held in DONE until out_ready=1.
//   - Throughput is one result every 9 cycles when out_ready is held high.
//
// Parameters
//   POLY       low 8 bits of the reduction polynomial; the x^8 term is
//              implicit. The default 8'h1B gives x^8 + x^4 + x^3 + x + 1.
//
// Configuration macro
//   GF_REDUCE_PROG_POLY_EN  when defined, adds the poly_in port. poly_in is
//                           captured on the accepting edge and used for that
//                           whole operation; POLY is then unused.
//
// Ports
//   clk        clock; all state changes on its rising edge
//   rst        synchronous, active-high reset
//   in_valid   in_data carries a product to reduce
//   in_ready   block can accept a product (IDLE only)
//   in_data    product, bit i = coefficient of x^i
//   out_valid  out_data holds a reduced result (DONE only)
//   out_ready  downstream accepts out_data this cycle
//   poly_in    per-operation polynomial (only with GF_REDUCE_PROG_POLY_EN)
//   out_data   in_data mod (x^8 + poly); 8'h00 whenever out_valid=0
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module gf_reduce_8 #(
    parameter logic [7:0] POLY = 8'h1B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef GF_REDUCE_PROG_POLY_EN
    input  logic [7:0]  poly_in,
`endif
    output logic [7:0]  out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [14:0] work_r;
    logic [3:0]  idx_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [7:0]  out_data_r;
    logic [7:0]  poly_s;
    logic [14:0] step_s;

    // One elimination step.
    // If bit idx is set, XOR in the full polynomial aligned so that its x^8
    // term lands on bit idx. That clears bit idx and folds its weight into
    // the lower bits.
    function automatic logic [14:0] reduce_step(
        input logic [14:0] work,
        input logic [3:0]  idx,
        input logic [7:0]  poly
    );
        logic [14:0] mask;
        mask = {6'd0, 1'b1, poly} << (idx - 4'd8);
        if (work[idx]) begin
            reduce_step = work ^ mask;
        end else begin
            reduce_step = work;
        end
    endfunction

`ifdef GF_REDUCE_PROG_POLY_EN
    logic [7:0] poly_r;

    // Capture poly_in on the accepting edge so that later changes to it
    // cannot disturb the operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            poly_r <= 8'h00;
        end else if (state_r == IDLE && in_valid) begin
            poly_r <= poly_in;
        end else begin
            poly_r <= poly_r;
        end
    end

    assign poly_s = poly_r;
`else
    assign poly_s = POLY;
`endif

    // Next value of the work register for the current bit index.
    always_comb begin
        step_s = reduce_step(work_r, idx_r, poly_s);
    end

    // Control FSM together with the datapath and the registered handshake
    // and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            work_r      <= 15'd0;
            idx_r       <= 4'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        work_r     <= in_data;
                        idx_r      <= 4'd14;
                        state_r    <= BUSY;
                        in_ready_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end

                BUSY: begin
                    work_r <= step_s;
                    // The step at idx 8 is always the last one, so BUSY
                    // has a fixed length of 7 cycles.
                    if (idx_r == 4'd8) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        out_data_r  <= step_s[7:0];
                    end else begin
                        idx_r <= idx_r - 4'd1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        out_data_r  <= 8'h00;
                    end else begin
                        state_r <= DONE;
                    end
                end

                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    out_data_r  <= 8'h00;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_gf_reduce_8.sv
`timescale 1ns/1ps

module tb_gf_reduce_8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [14:0] in_data = 15'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
`ifdef GF_REDUCE_PROG_POLY_EN
    logic [7:0]  poly_in = 8'h1B;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    always #5 clk = ~clk;

    gf_reduce_8 #(.POLY(8'h1B)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef GF_REDUCE_PROG_POLY_EN
        .poly_in   (poly_in),
`endif
        .out_data  (out_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the sum of (x^i mod p) over the set bits of d. x^i mod p is
    // obtained by repeated multiply-by-x.
    function automatic logic [7:0] gf_mod(input logic [14:0] d, input logic [7:0] p);
        logic [7:0] acc;
        logic [7:0] xp;
        acc = 8'h00;
        xp  = 8'h01;
        for (int i = 0; i < 15; i++) begin
            if (d[i]) acc = acc ^ xp;
            xp = {xp[6:0], 1'b0} ^ (xp[7] ? p : 8'h00);
        end
        return acc;
    endfunction

    // Cycle-level model.
    //   phase 0 = accepting
    //   phase 1 = working (left = cycles to go)
    //   phase 2 = presenting
    int         m_phase  = 0;
    int         m_left   = 0;
    logic [7:0] m_result = 8'h00;

    function automatic logic [7:0] poly_now();
`ifdef GF_REDUCE_PROG_POLY_EN
        return poly_in;
`else
        return 8'h1B;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase  <= 0;
            m_left   <= 0;
            m_result <= 8'h00;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_phase  <= 1;
                m_left   <= 7;
                m_result <= gf_mod(in_data, poly_now());
            end
        end else if (m_phase == 1) begin
            if (m_left == 1) m_phase <= 2;
            m_left <= m_left - 1;
        end else begin
            if (out_ready) m_phase <= 0;
        end
    end

    // Compare the DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (armed) begin
            check("cyc_in_ready",  {31'd0, in_ready},  {31'd0, m_phase == 0});
            check("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
            check("cyc_out_data",  {24'd0, out_data},  {24'd0, (m_phase == 2) ? m_result : 8'h00});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, then present one product for exactly one accept edge.
    task automatic accept(input logic [14:0] d);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid rises.
    task automatic wait_result(output int edges);
        edges = 1;
        tick();
        while (!out_valid && edges < 30) begin
            tick();
            edges++;
        end
    endtask

    task automatic run_op(input string name, input logic [14:0] d,
                          input logic [7:0] exp, input int hold);
        int lat;
        out_ready = (hold == 0);
        accept(d);
        wait_result(lat);
        check({name, "_latency"}, lat, 32'd7);
        check({name, "_data"}, {24'd0, out_data}, {24'd0, exp});
        for (int k = 0; k < hold; k++) begin
            tick();
            check({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({name, "_hold_data"},  {24'd0, out_data},  {24'd0, exp});
            check({name, "_hold_ready"}, {31'd0, in_ready},  32'd0);
        end
        out_ready = 1'b1;
        tick();
        check({name, "_idle_ready"}, {31'd0, in_ready},  32'd1);
        check({name, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        check({name, "_idle_data"},  {24'd0, out_data},  32'd0);
    endtask

    initial begin
        int lat;
        int t0;
        int t1;
        int cyc;

        // Pin the reference against hand-computed values.
        check("ref_2B79", {24'd0, gf_mod(15'h2B79, 8'h1B)}, 32'hC1);
        check("ref_4000", {24'd0, gf_mod(15'h4000, 8'h1B)}, 32'h9A);
        check("ref_00FF", {24'd0, gf_mod(15'h00FF, 8'h1B)}, 32'hFF);
        check("ref_0100", {24'd0, gf_mod(15'h0100, 8'h1B)}, 32'h1B);

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {24'd0, out_data},  32'd0);
        armed = 1'b1;
        tick();

        // Directed vectors.
        run_op("v2B79", 15'h2B79, 8'hC1, 0);
        run_op("v4000", 15'h4000, 8'h9A, 0);
        run_op("v00FF", 15'h00FF, 8'hFF, 0);
        run_op("v0000", 15'h0000, 8'h00, 0);
        run_op("v7FFF", 15'h7FFF, gf_mod(15'h7FFF, 8'h1B), 0);
        run_op("v0100", 15'h0100, 8'h1B, 0);

        // Back-pressure: hold the result for 5 cycles.
        run_op("hold", 15'h2B79, 8'hC1, 5);

        // Reset in the 3rd BUSY cycle: the operation is discarded.
        accept(15'h2B79);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready",  {31'd0, in_ready},  32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_out_data",  {24'd0, out_data},  32'd0);
        for (int k = 0; k < 12; k++) begin
            tick();
            check("abort_no_result", {31'd0, out_valid}, 32'd0);
        end

        // New data toggling in while BUSY must be ignored.
        out_ready = 1'b1;
        accept(15'h2B79);
        for (int k = 0; k < 6; k++) begin
            in_valid = k[0];
            in_data  = (k[0]) ? 15'h7FFF : 15'h4000;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("ignore_valid", {31'd0, out_valid}, 32'd1);
        check("ignore_data",  {24'd0, out_data},  32'hC1);
        tick();
        check("ignore_idle", {31'd0, in_ready}, 32'd1);

        // Sustained throughput: one result every 9 cycles.
        in_data   = 15'h4000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        t0 = cyc;
        tick();
        cyc++;
        while (!out_valid && cyc < 80) begin
            tick();
            cyc++;
        end
        t1 = cyc;
        check("throughput_period", t1 - t0, 32'd9);
        in_valid = 1'b0;
        repeat (12) tick();

`ifdef GF_REDUCE_PROG_POLY_EN
        // poly_in is sampled at accept; a later change must not matter.
        poly_in   = 8'h1B;
        out_ready = 1'b1;
        accept(15'h2B79);
        poly_in = 8'h00;
        lat = 1;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        check("prog_latency", lat, 32'd7);
        check("prog_data", {24'd0, out_data}, 32'hC1);
        tick();
        poly_in = 8'h1B;
        tick();
`else
        lat = 0;
`endif

        armed = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
